// File: rtl/fft_bfly_round.sv
// Radix-2 DIT butterfly after the complex multiplier: aligns A with the product, rounds, adds/subtracts,
// scales and clips to 18 bits, and tracks per-frame overflow. Define BFLY_SAT_EN to saturate; otherwise outputs wrap.
module fft_bfly_round #(
   parameter int MUL_LAT   = 6,
   parameter int FRAC_BITS = 17,
   parameter int SCALE     = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   input  logic               in_last,
   input  logic signed [17:0] a_real,
   input  logic signed [17:0] a_imag,
   input  logic signed [35:0] prod_real,
   input  logic signed [35:0] prod_imag,
   output logic               out_valid,
   output logic               out_last,
   output logic signed [17:0] x_real,
   output logic signed [17:0] x_imag,
   output logic signed [17:0] y_real,
   output logic signed [17:0] y_imag,
   output logic               ovf_frame,
   output logic               sat_any
);

   // Valid is a plain strobe with no backpressure: a sample is accepted on every clock where in_valid is high,
   // and out_valid marks the matching result exactly MUL_LAT + 2 clocks later.
   localparam logic signed [36:0] RND = 37'sd1 <<< (FRAC_BITS - 1);

   logic [MUL_LAT-1:0][17:0] dly_ar_q, dly_ar_d;
   logic [MUL_LAT-1:0][17:0] dly_ai_q, dly_ai_d;
   logic [MUL_LAT-1:0]       dly_v_q, dly_v_d;
   logic [MUL_LAT-1:0]       dly_l_q, dly_l_d;

   logic signed [18:0] pr_r_q, pr_r_d, pr_i_q, pr_i_d;
   logic signed [17:0] ar_r_q, ar_r_d, ai_r_q, ai_r_d;
   logic               v_r_q, v_r_d, l_r_q, l_r_d;

   logic signed [17:0] x_real_q, x_real_d, x_imag_q, x_imag_d;
   logic signed [17:0] y_real_q, y_real_d, y_imag_q, y_imag_d;
   logic               out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic               ovf_frame_q, ovf_frame_d, sat_any_q, sat_any_d;
   logic               ovf_acc_q, ovf_acc_d;

   logic signed [36:0] rnd_r, rnd_i, shr_r, shr_i;
   logic signed [19:0] sum_xr, sum_xi, dif_yr, dif_yi;
   logic [18:0]        res_xr, res_xi, res_yr, res_yi;
   logic               sat_evt;

   // Returns {clip, value}: clip flags a result outside the 18-bit range, whether or not it is saturated.
   function automatic logic [18:0] bfly_out(input logic signed [19:0] v);
      logic signed [20:0] s;
      logic               clip;
      logic [17:0]        w;
      if (SCALE == 1) s = (21'(v) + 21'sd1) >>> 1;
      else            s = 21'(v);
      clip = (s > 21'sd131071) || (s < -21'sd131072);
`ifdef BFLY_SAT_EN
      if (s > 21'sd131071)       w = 18'h1ffff;
      else if (s < -21'sd131072) w = 18'h20000;
      else                       w = s[17:0];
`else
      w = s[17:0];
`endif
      return {clip, w};
   endfunction

   always_comb begin
      dly_ar_d    = dly_ar_q;
      dly_ai_d    = dly_ai_q;
      dly_v_d     = dly_v_q;
      dly_l_d     = dly_l_q;
      dly_ar_d[0] = a_real;
      dly_ai_d[0] = a_imag;
      dly_v_d[0]  = in_valid;
      dly_l_d[0]  = in_last;
      for (int i = 1; i < MUL_LAT; i++) begin
         dly_ar_d[i] = dly_ar_q[i-1];
         dly_ai_d[i] = dly_ai_q[i-1];
         dly_v_d[i]  = dly_v_q[i-1];
         dly_l_d[i]  = dly_l_q[i-1];
      end
   end

   // Stage R: round-half-up of the product back to the working fraction width.
   always_comb begin
      rnd_r  = 37'(prod_real) + RND;
      rnd_i  = 37'(prod_imag) + RND;
      shr_r  = rnd_r >>> FRAC_BITS;
      shr_i  = rnd_i >>> FRAC_BITS;
      pr_r_d = shr_r[18:0];
      pr_i_d = shr_i[18:0];
      ar_r_d = dly_ar_q[MUL_LAT-1];
      ai_r_d = dly_ai_q[MUL_LAT-1];
      v_r_d  = dly_v_q[MUL_LAT-1];
      l_r_d  = dly_l_q[MUL_LAT-1];
   end

   // Stage B: butterfly, scale, clip, and overflow bookkeeping.
   always_comb begin
      sum_xr = 20'(ar_r_q) + 20'(pr_r_q);
      sum_xi = 20'(ai_r_q) + 20'(pr_i_q);
      dif_yr = 20'(ar_r_q) - 20'(pr_r_q);
      dif_yi = 20'(ai_r_q) - 20'(pr_i_q);
      res_xr = bfly_out(sum_xr);
      res_xi = bfly_out(sum_xi);
      res_yr = bfly_out(dif_yr);
      res_yi = bfly_out(dif_yi);
      sat_evt = v_r_q & (res_xr[18] | res_xi[18] | res_yr[18] | res_yi[18]);

      x_real_d = x_real_q;
      x_imag_d = x_imag_q;
      y_real_d = y_real_q;
      y_imag_d = y_imag_q;
      if (v_r_q) begin
         x_real_d = res_xr[17:0];
         x_imag_d = res_xi[17:0];
         y_real_d = res_yr[17:0];
         y_imag_d = res_yi[17:0];
      end
      out_valid_d = v_r_q;
      out_last_d  = v_r_q & l_r_q;
      ovf_frame_d = v_r_q & l_r_q & (ovf_acc_q | sat_evt);
      ovf_acc_d   = ovf_acc_q;
      if (v_r_q) ovf_acc_d = l_r_q ? 1'b0 : (ovf_acc_q | sat_evt);
      sat_any_d   = sat_any_q | sat_evt;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         dly_ar_q    <= '0;
         dly_ai_q    <= '0;
         dly_v_q     <= '0;
         dly_l_q     <= '0;
         pr_r_q      <= '0;
         pr_i_q      <= '0;
         ar_r_q      <= '0;
         ai_r_q      <= '0;
         v_r_q       <= 1'b0;
         l_r_q       <= 1'b0;
         x_real_q    <= '0;
         x_imag_q    <= '0;
         y_real_q    <= '0;
         y_imag_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         ovf_frame_q <= 1'b0;
         ovf_acc_q   <= 1'b0;
         sat_any_q   <= 1'b0;
      end else begin
         dly_ar_q    <= dly_ar_d;
         dly_ai_q    <= dly_ai_d;
         dly_v_q     <= dly_v_d;
         dly_l_q     <= dly_l_d;
         pr_r_q      <= pr_r_d;
         pr_i_q      <= pr_i_d;
         ar_r_q      <= ar_r_d;
         ai_r_q      <= ai_r_d;
         v_r_q       <= v_r_d;
         l_r_q       <= l_r_d;
         x_real_q    <= x_real_d;
         x_imag_q    <= x_imag_d;
         y_real_q    <= y_real_d;
         y_imag_q    <= y_imag_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         ovf_frame_q <= ovf_frame_d;
         ovf_acc_q   <= ovf_acc_d;
         sat_any_q   <= sat_any_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign x_real    = x_real_q;
   assign x_imag    = x_imag_q;
   assign y_real    = y_real_q;
   assign y_imag    = y_imag_q;
   assign ovf_frame = ovf_frame_q;
   assign sat_any   = sat_any_q;

endmodule

// File: tb/tb_fft_bfly_round.sv
// Scoreboard bench for fft_bfly_round: one instance with SCALE=0 and one with SCALE=1 share the stimulus.
module tb_fft_bfly_round;
   localparam int LAT = 6;

   typedef struct packed {
      logic signed [17:0] xr, xi, yr, yi;
   } res_t;

   typedef struct {
      logic signed [17:0] ar, ai;
      logic signed [35:0] pr, pi;
      res_t               e0;
      bit                 c0;
      res_t               e1;
      bit                 c1;
   } vec_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic               reset = 1'b1, in_valid = 1'b0, in_last = 1'b0;
   logic signed [17:0] a_real = '0, a_imag = '0;
   logic signed [35:0] prod_real = '0, prod_imag = '0;

   logic               v0, l0, o0, s0, v1, l1, o1, s1;
   logic signed [17:0] xr0, xi0, yr0, yi0, xr1, xi1, yr1, yi1;

   fft_bfly_round #(.MUL_LAT(LAT), .FRAC_BITS(17), .SCALE(0)) dut_s0 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_last(in_last),
      .a_real(a_real), .a_imag(a_imag), .prod_real(prod_real), .prod_imag(prod_imag),
      .out_valid(v0), .out_last(l0), .x_real(xr0), .x_imag(xi0), .y_real(yr0), .y_imag(yi0),
      .ovf_frame(o0), .sat_any(s0));

   fft_bfly_round #(.MUL_LAT(LAT), .FRAC_BITS(17), .SCALE(1)) dut_s1 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_last(in_last),
      .a_real(a_real), .a_imag(a_imag), .prod_real(prod_real), .prod_imag(prod_imag),
      .out_valid(v1), .out_last(l1), .x_real(xr1), .x_imag(xi1), .y_real(yr1), .y_imag(yi1),
      .ovf_frame(o1), .sat_any(s1));

   // Expected entry: {out_last, ovf_frame, sat_any, x_real, x_imag, y_real, y_imag}
   logic [74:0] exp0_q[$];
   logic [74:0] exp1_q[$];
   logic        acc0 = 1'b0, acc1 = 1'b0, sat0 = 1'b0, sat1 = 1'b0;
   logic signed [35:0] pipe_r[LAT];
   logic signed [35:0] pipe_i[LAT];
   int checks = 0, passes = 0;
   vec_t tbl[7];
   vec_t zv;

   function automatic res_t mkres(input int xr, input int xi, input int yr, input int yi);
      res_t r;
      r.xr = 18'(xr); r.xi = 18'(xi); r.yr = 18'(yr); r.yi = 18'(yi);
      return r;
   endfunction

   function automatic vec_t mkv(input int ar, input int ai, input longint pr, input longint pi,
                                input res_t e0, input bit c0, input res_t e1, input bit c1);
      vec_t v;
      v.ar = 18'(ar); v.ai = 18'(ai); v.pr = 36'(pr); v.pi = 36'(pi);
      v.e0 = e0; v.c0 = c0; v.e1 = e1; v.c1 = c1;
      return v;
   endfunction

   task automatic drive(input bit rst, input bit v, input bit l, input vec_t t);
      logic ovf;
      @(posedge clock); #1;
      reset     = rst;
      in_valid  = v;
      in_last   = l;
      a_real    = t.ar;
      a_imag    = t.ai;
      prod_real = pipe_r[LAT-1];
      prod_imag = pipe_i[LAT-1];
      for (int i = LAT - 1; i > 0; i--) begin
         pipe_r[i] = pipe_r[i-1];
         pipe_i[i] = pipe_i[i-1];
      end
      pipe_r[0] = v ? t.pr : 36'sd0;
      pipe_i[0] = v ? t.pi : 36'sd0;
      if (rst) begin
         exp0_q.delete();
         exp1_q.delete();
         acc0 = 1'b0; acc1 = 1'b0; sat0 = 1'b0; sat1 = 1'b0;
         for (int i = 0; i < LAT; i++) begin
            pipe_r[i] = '0;
            pipe_i[i] = '0;
         end
      end else if (v) begin
         sat0 = sat0 | t.c0;
         ovf  = l & (acc0 | t.c0);
         acc0 = l ? 1'b0 : (acc0 | t.c0);
         exp0_q.push_back({l, ovf, sat0, t.e0});
         sat1 = sat1 | t.c1;
         ovf  = l & (acc1 | t.c1);
         acc1 = l ? 1'b0 : (acc1 | t.c1);
         exp1_q.push_back({l, ovf, sat1, t.e1});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, zv);
   endtask

   task automatic mon(input int inst, input logic v, input logic l, input logic o, input logic s,
                      input res_t r);
      logic [74:0] a, e;
      a = {l, o, s, r};
      checks++;
      if (v) begin
         if ((inst == 0) ? (exp0_q.size() == 0) : (exp1_q.size() == 0)) begin
            $display("FAIL unexpected_valid inst%0d act=%h exp=none", inst, a);
         end else begin
            e = (inst == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
            if (a !== e) $display("FAIL output inst%0d act=%h exp=%h", inst, a, e);
            else passes++;
         end
      end else begin
         if ({l, o} !== 2'b00) $display("FAIL idle_flags inst%0d act=%b exp=00", inst, {l, o});
         else passes++;
      end
   endtask

   always @(negedge clock) begin
      if (reset === 1'b0) begin
         mon(0, v0, l0, o0, s0, {xr0, xi0, yr0, yi0});
         mon(1, v1, l1, o1, s1, {xr1, xi1, yr1, yi1});
      end
   end

   task automatic check_zero(input string name);
      checks++;
      if ({v0, l0, o0, s0, xr0, xi0, yr0, yi0} !== 76'd0)
         $display("FAIL %s inst0 act=%h exp=0", name, {v0, l0, o0, s0, xr0, xi0, yr0, yi0});
      else passes++;
      checks++;
      if ({v1, l1, o1, s1, xr1, xi1, yr1, yi1} !== 76'd0)
         $display("FAIL %s inst1 act=%h exp=0", name, {v1, l1, o1, s1, xr1, xi1, yr1, yi1});
      else passes++;
   endtask

   initial begin
      for (int i = 0; i < LAT; i++) begin
         pipe_r[i] = '0;
         pipe_i[i] = '0;
      end
      zv = mkv(0, 0, 0, 0, mkres(0, 0, 0, 0), 1'b0, mkres(0, 0, 0, 0), 1'b0);
      tbl[0] = mkv(1000, 0, 131072000, 0, mkres(2000, 0, 0, 0), 1'b0, mkres(1000, 0, 0, 0), 1'b0);
      tbl[1] = mkv(0, 0, 65536, 0, mkres(1, 0, -1, 0), 1'b0, mkres(1, 0, 0, 0), 1'b0);
      tbl[2] = mkv(0, 0, -65536, 0, mkres(0, 0, 0, 0), 1'b0, mkres(0, 0, 0, 0), 1'b0);
      tbl[3] = mkv(0, 0, -65537, 0, mkres(-1, 0, 1, 0), 1'b0, mkres(0, 0, 1, 0), 1'b0);
`ifdef BFLY_SAT_EN
      tbl[4] = mkv(131071, -131072, 64'sd17179738112, 64'sd17179738112,
                   mkres(131071, -1, 0, -131072), 1'b1, mkres(131071, 0, 0, -131071), 1'b0);
      tbl[5] = mkv(131071, 0, 64'sd26214400000, 0,
                   mkres(131071, 0, -68929, 0), 1'b1, mkres(131071, 0, -34464, 0), 1'b1);
`else
      tbl[4] = mkv(131071, -131072, 64'sd17179738112, 64'sd17179738112,
                   mkres(-2, -1, 0, 1), 1'b1, mkres(131071, 0, 0, -131071), 1'b0);
      tbl[5] = mkv(131071, 0, 64'sd26214400000, 0,
                   mkres(68927, 0, -68929, 0), 1'b1, mkres(-96608, 0, -34464, 0), 1'b1);
`endif
      tbl[6] = mkv(-500, 300, -26214400, 196608, mkres(-700, 302, -300, 298), 1'b0,
                   mkres(-350, 151, -150, 149), 1'b0);

      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, zv);
      drive(1'b0, 1'b0, 1'b0, zv);
      check_zero("reset_state");

      // Alignment and latency: single sample, nothing else may appear
      drive(1'b0, 1'b1, 1'b1, tbl[0]);
      idle(10);
      // Rounding boundaries, then an imaginary-channel half-up case
      drive(1'b0, 1'b1, 1'b0, tbl[1]);
      drive(1'b0, 1'b1, 1'b0, tbl[2]);
      drive(1'b0, 1'b1, 1'b1, tbl[3]);
      drive(1'b0, 1'b1, 1'b1, tbl[6]);
      idle(3);
      // Single-sample frame that clips under SCALE=0 only
      drive(1'b0, 1'b1, 1'b1, tbl[4]);
      idle(4);
      // Four-sample frame clipping on sample 2, then a clean frame
      drive(1'b0, 1'b1, 1'b0, tbl[0]);
      drive(1'b0, 1'b1, 1'b0, tbl[5]);
      drive(1'b0, 1'b1, 1'b0, tbl[1]);
      drive(1'b0, 1'b1, 1'b1, tbl[3]);
      drive(1'b0, 1'b1, 1'b0, tbl[0]);
      drive(1'b0, 1'b1, 1'b0, tbl[1]);
      drive(1'b0, 1'b1, 1'b0, tbl[2]);
      drive(1'b0, 1'b1, 1'b1, tbl[6]);
      idle(10);
      // Back-to-back ramp
      for (int n = 0; n < 16; n++)
         drive(1'b0, 1'b1, (n == 15), mkv(n, 0, 0, 0, mkres(n, 0, n, 0), 1'b0,
                                          mkres((n + 1) / 2, 0, (n + 1) / 2, 0), 1'b0));
      idle(10);
      // Reset in the middle of a continuous stream
      for (int k = 0; k < 10; k++) begin
         drive((k == 5), 1'b1, 1'b0, mkv(k + 100, 7, 0, 0, mkres(k + 100, 7, k + 100, 7), 1'b0,
                                        mkres((k + 101) / 2, 4, (k + 101) / 2, 4), 1'b0));
         if (k == 6) check_zero("reset_mid_stream");
      end
      idle(12);

      checks++;
      if (exp0_q.size() != 0) $display("FAIL drain inst0 act=%0d exp=0 pending", exp0_q.size());
      else passes++;
      checks++;
      if (exp1_q.size() != 0) $display("FAIL drain inst1 act=%0d exp=0 pending", exp1_q.size());
      else passes++;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fft_bfly_round.md
Name: fft_bfly_round

Overview:
- Radix-2 DIT butterfly stage that sits directly downstream of the 6-clock complex multiplier in the FFT datapath.
- Aligns the upper operand A with the full-precision 36-bit twiddle product P, rounds P to working width, and forms X = A + P and Y = A − P.
- Optionally scales by 1/2 and saturates to 18-bit outputs for the next FFT stage.
- Tracks per-frame overflow so the FFT controller can apply block scaling.

Parameters:
- MUL_LAT, 6: multiplier latency in clocks; depth of the internal A/valid/last delay line (1..16).
- FRAC_BITS, 17: twiddle fraction bits; product right-shift amount (Q1.17 twiddles).
- SCALE, 1: extra output shift; 0 = none, 1 = divide by 2 with rounding.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  A and multiplier operands presented this cycle
- in_last  in  1  marks the final butterfly of a frame; qualified by in_valid
- a_real  in  18  upper operand A, real part, signed; same cycle as multiplier inputs
- a_imag  in  18  upper operand A, imaginary part, signed
- prod_real  in  36  multiplier result_real, signed; valid MUL_LAT clocks after in_valid
- prod_imag  in  36  multiplier result_imag, signed
- out_valid  out  1  X/Y valid
- out_last  out  1  last butterfly of the frame
- x_real, x_imag  out  18 each  A + P, scaled/saturated
- y_real, y_imag  out  18 each  A − P, scaled/saturated
- ovf_frame  out  1  one-cycle pulse, coincident with out_last, if any output clipped during that frame
- sat_any  out  1  sticky: any clip since reset

Behaviour:
- Reset (synchronous):
  - Clears every delay-line stage, valid/last pipeline, frame-overflow accumulator and sat_any.
  - All outputs read 0 on the cycle after reset is sampled.
  - Reset mid-frame discards all in-flight samples; no out_valid until new in_valid + latency.
- Delay line:
  - a_real/a_imag/in_valid/in_last shift through MUL_LAT registers every clock, independent of valid.
  - Gaps in in_valid are allowed; no backpressure.
- Stage R (1 clk):
  - Pr = (prod + 2^(FRAC_BITS−1)) >>> FRAC_BITS, computed in 37 bits, kept as 19-bit signed.
  - Rounding is round-half-up; e.g. 65536 → 1, −65536 → 0, −65537 → −1.
  - The delayed A is registered alongside Pr.
- Stage B (1 clk):
  - X = A + Pr and Y = A − Pr, both 20-bit.
  - If SCALE = 1: (v + 1) >>> 1.
  - Result is then clipped to the 18-bit range [−131072, 131071] and registered to the outputs.
- Latency: out_valid = in_valid delayed MUL_LAT + 2 clocks (8 at defaults). Throughput is 1 butterfly per clock.
- Saturation event: any of the four outputs requiring a clip while out_valid = 1.
- Frame overflow accumulator:
  - OR of saturation events since the last out_last.
  - ovf_frame = accumulator OR the current cycle's event, asserted only when out_valid & out_last.
  - Accumulator clears on that cycle.
  - Events with out_valid = 0 are ignored.
- sat_any sets on any saturation event; it is cleared only by reset.
- Frame of length 1 (in_last on every sample) is legal; ovf_frame reflects that sample alone.
- Outputs hold their last value while out_valid = 0.

Optional Feature:
- Macro: BFLY_SAT_EN.
- Defined: clipping, sat_any and ovf_frame behave as above.
- Undefined:
  - Outputs take the low 18 bits of the scaled result (two's-complement wrap).
  - Overflow detection still drives sat_any and ovf_frame, so the controller can still rescale.

Test Plan:
- Align/latency, SCALE = 1: in_valid pulse at t0, A = (1000, 0), prod = (131072000, 0) at t0+6 → out_valid at t0+8 only; X = (1000, 0), Y = (0, 0).
- Rounding, A = 0, SCALE = 0:
  - prod_real = 65536 → x_real = 1, y_real = −1.
  - prod_real = −65536 → x_real = 0, y_real = 0.
  - prod_real = −65537 → x_real = −1, y_real = 1.
- Saturation, SCALE = 0, A = (131071, −131072), P = (131071, 131071) via prod = 131071·2^17:
  - X = (131071, −1), Y = (0, −131072).
  - With BFLY_SAT_EN defined: x_real clips → sat_any = 1.
- Frame overflow: 4-sample frame with a clip on sample 2 only, in_last on sample 4 → ovf_frame pulses with out_last; the next clean frame gives ovf_frame = 0.
- Reset mid-stream: continuous in_valid for 10 clocks, reset at clock 5 for 1 cycle → all outputs 0 the next cycle; no out_valid for the 5 pre-reset samples; post-reset samples emerge at +8.
- Back-to-back: 16 consecutive samples with a ramp A = n, prod = 0 → out_valid high for exactly 16 clocks.
  - Under SCALE = 1: x_real = y_real = (n+1)>>>1.
